// File: rtl/module_gray_input.sv
// Switch front end: synchronises a Gray-coded switch word, debounces it and
// presents the settled value as binary with a one-cycle strobe per new code.
module module_gray_input #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_code,
  output logic             code_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= gray_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
    end
  end

  // A candidate that drifts back to the committed code is dropped silently.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync2_q != cand_q) begin
          if (sync2_q == stable_q) begin
            state_d = IDLE;
          end else begin
            cand_d = sync2_q;
            cnt_d  = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          stable_d = cand_q;
          bin_d    = g2b(cand_q);
          valid_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign binary_code = bin_q;
  assign code_valid  = valid_q;
  assign busy        = (state_q == COUNT);

endmodule

// File: tb/tb_module_gray_input.sv
// Bench for module_gray_input with a short debounce window; commits are
// scored against a queue of expected codes filled as stimulus is driven.
module tb_module_gray_input;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] expBin;
    int         hold;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] gray_in = '0;
  logic [WIDTH-1:0] binary_code;
  logic             code_valid;
  logic             busy;

  int         compared = 0;
  int         mismatched = 0;
  int         pulseCount = 0;
  logic [3:0] expQ[$];
  vec_t       sweep[16];

  module_gray_input #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in),
    .binary_code(binary_code), .code_valid(code_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g);
    @(negedge clk);
    gray_in = g;
  endtask

  // Edge 0 is the first rising edge after the new value appears.
  task automatic watchEdges(input string name, input logic [3:0] expBin, input bit checkBusy);
    for (int e = 0; e <= 7; e++) begin
      @(posedge clk); #1;
      checkOutput({name, "_valid"}, 32'(code_valid), 32'(e == 6));
      if (checkBusy) checkOutput({name, "_busy"}, 32'(busy), 32'(e >= 2 && e <= 5));
      if (e == 6) checkOutput({name, "_bin"}, 32'(binary_code), 32'(expBin));
    end
  endtask

  task automatic settleCheck(input string name, input logic [3:0] g, input logic [3:0] expBin, input bit checkBusy);
    expQ.push_back(expBin);
    applyStimulus(g);
    watchEdges(name, expBin, checkBusy);
  endtask

  // Every strobe must match the oldest outstanding expected commit.
  always begin
    @(posedge clk); #1;
    if (code_valid === 1'b1) begin
      pulseCount++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: got pulse with code %0h, required no pulse", binary_code);
      end else begin
        checkOutput("commit_value", 32'(binary_code), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, required finish within 20000 cycles");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0;
    sweep = '{
      '{4'b0000, 4'b0000, 10}, '{4'b0001, 4'b0001, 10}, '{4'b0011, 4'b0010, 10}, '{4'b0010, 4'b0011, 10},
      '{4'b0110, 4'b0100, 10}, '{4'b0111, 4'b0101, 10}, '{4'b0101, 4'b0110, 10}, '{4'b0100, 4'b0111, 10},
      '{4'b1100, 4'b1000, 10}, '{4'b1101, 4'b1001, 10}, '{4'b1111, 4'b1010, 10}, '{4'b1110, 4'b1011, 10},
      '{4'b1010, 4'b1100, 10}, '{4'b1011, 4'b1101, 10}, '{4'b1001, 4'b1110, 10}, '{4'b1000, 4'b1111, 10}
    };

    #2;
    checkOutput("reset_bin", 32'(binary_code), 32'h0);
    checkOutput("reset_valid", 32'(code_valid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_busy", 32'(busy), 32'h0);
      checkOutput("idle_valid", 32'(code_valid), 32'h0);
    end
    checkOutput("idle_bin", 32'(binary_code), 32'h0);

    settleCheck("first", 4'b0110, 4'b0100, 1'b1);

    applyStimulus(4'b1110);
    fork
      begin
        @(negedge clk);
        applyStimulus(4'b0110);
      end
      for (int e = 0; e <= 9; e++) begin
        @(posedge clk); #1;
        checkOutput("bounce_busy", 32'(busy), 32'(e == 2 || e == 3));
        checkOutput("bounce_valid", 32'(code_valid), 32'h0);
      end
    join
    checkOutput("bounce_bin", 32'(binary_code), 32'h4);

    p0 = pulseCount;
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b1000 : 4'b1001);
      @(negedge clk);
    end
    settleCheck("glitch", 4'b1000, 4'b1111, 1'b0);
    checkOutput("glitch_pulses", 32'(pulseCount - p0), 32'd1);

    p0 = pulseCount;
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(sweep[i].expBin);
      applyStimulus(sweep[i].gray);
      repeat (sweep[i].hold - 1) @(negedge clk);
      checkOutput("sweep_bin", 32'(binary_code), 32'(sweep[i].expBin));
    end
    checkOutput("sweep_pulses", 32'(pulseCount - p0), 32'd16);

    applyStimulus(4'b0000);
    repeat (4) @(posedge clk);
    #3;
    checkOutput("precut_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    gray_in = 4'b0101;
    #1;
    checkOutput("cut_bin", 32'(binary_code), 32'h0);
    checkOutput("cut_busy", 32'(busy), 32'h0);
    checkOutput("cut_valid", 32'(code_valid), 32'h0);
    repeat (3) @(posedge clk);
    expQ.push_back(4'b0110);
    @(negedge clk);
    rst_n = 1'b1;
    watchEdges("release", 4'b0110, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
